// File: rtl/reg_bank_16x32.sv
// 16-entry register bank with two registered read ports, one write port and a clear sweep.
// Defining REG_BANK_BYPASS_EN forwards same-edge write data to a matching read port.
module reg_bank_16x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    input  logic                  READ,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2,
    output logic                  R_VALID,
    input  logic                  CLR_REQ,
    output logic                  BUSY
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] r1_q, r1_d;
    logic [DATA_WIDTH-1:0] r2_q, r2_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rd1, rd2;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        r1_d     = r1_q;
        r2_d     = r2_q;
        rvalid_d = 1'b0;
        rd1      = mem_q[ADDR_R1];
        rd2      = mem_q[ADDR_R2];
`ifdef REG_BANK_BYPASS_EN
        if (WRITE && (ADDR_W == ADDR_R1)) rd1 = DATA_W;
        if (WRITE && (ADDR_W == ADDR_R2)) rd2 = DATA_W;
`endif
        case (state_q)
            ST_IDLE: begin
                if (READ) begin
                    r1_d     = rd1;
                    r2_d     = rd2;
                    rvalid_d = 1'b1;
                end
                if (CLR_REQ) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                // Last entry cleared on this edge; the counter wraps back to zero.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            r1_q     <= '0;
            r2_q     <= '0;
            rvalid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            r1_q     <= r1_d;
            r2_q     <= r2_d;
            rvalid_q <= rvalid_d;
            if ((state_q == ST_IDLE) && WRITE) begin
                mem_q[ADDR_W] <= DATA_W;
            end else if (state_q == ST_CLEAR) begin
                mem_q[cnt_q] <= '0;
            end
        end
    end

    assign DATA_R1 = r1_q;
    assign DATA_R2 = r2_q;
    assign R_VALID = rvalid_q;
    assign BUSY    = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_reg_bank_16x32.sv
// Randomized bench for reg_bank_16x32 against an array-based model, plus directed literal scenarios.
module tb_reg_bank_16x32;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        WRITE = 1'b0;
    logic [3:0]  ADDR_W = '0;
    logic [31:0] DATA_W = '0;
    logic        READ = 1'b0;
    logic [3:0]  ADDR_R1 = '0;
    logic [3:0]  ADDR_R2 = '0;
    logic [31:0] DATA_R1, DATA_R2;
    logic        R_VALID;
    logic        CLR_REQ = 1'b0;
    logic        BUSY;

    int checksTotal = 0;
    int checksPassed = 0;
    bit compareEn = 1'b0;

    logic [31:0] mMem [16];
    logic [31:0] mR1 = '0;
    logic [31:0] mR2 = '0;
    logic        mValid = 1'b0;
    int          mSweep = -1;

    reg_bank_16x32 dut (
        .CLK(CLK), .RST(RST), .WRITE(WRITE), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .READ(READ), .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2),
        .DATA_R1(DATA_R1), .DATA_R2(DATA_R2), .R_VALID(R_VALID),
        .CLR_REQ(CLR_REQ), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) checksPassed++;
        else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    endtask

    task automatic applyStimulus(input logic wr, input logic [3:0] aw, input logic [31:0] dw,
                                 input logic rd, input logic [3:0] a1, input logic [3:0] a2,
                                 input logic clr, input logic rst);
        WRITE = wr; ADDR_W = aw; DATA_W = dw;
        READ = rd; ADDR_R1 = a1; ADDR_R2 = a2;
        CLR_REQ = clr; RST = rst;
        @(posedge CLK);
        #1;
        WRITE = 1'b0; READ = 1'b0; CLR_REQ = 1'b0; RST = 1'b0;
    endtask

    // Reference: entries as a plain array, the sweep as "next index to clear" or -1 when idle.
    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) mMem[i] = '0;
            mR1 = '0; mR2 = '0; mValid = 1'b0; mSweep = -1;
        end else if (mSweep >= 0) begin
            mMem[mSweep] = '0;
            mValid = 1'b0;
            mSweep = (mSweep == 15) ? -1 : mSweep + 1;
        end else begin
            mValid = READ;
            if (READ) begin
                mR1 = mMem[ADDR_R1];
                mR2 = mMem[ADDR_R2];
`ifdef REG_BANK_BYPASS_EN
                if (WRITE && ADDR_W == ADDR_R1) mR1 = DATA_W;
                if (WRITE && ADDR_W == ADDR_R2) mR2 = DATA_W;
`endif
            end
            if (WRITE) mMem[ADDR_W] = DATA_W;
            if (CLR_REQ) mSweep = 0;
        end
    end

    always @(negedge CLK) begin
        if (compareEn) begin
            checkOutput("cyc_DATA_R1", DATA_R1, mR1);
            checkOutput("cyc_DATA_R2", DATA_R2, mR2);
            checkOutput("cyc_R_VALID", {31'b0, R_VALID}, {31'b0, mValid});
            checkOutput("cyc_BUSY", {31'b0, BUSY}, {31'b0, (mSweep >= 0)});
        end
    end

    initial begin
        int busyCycles;
        int guard;

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        compareEn = 1'b1;
        checkOutput("reset_BUSY", {31'b0, BUSY}, 32'd0);
        checkOutput("reset_R_VALID", {31'b0, R_VALID}, 32'd0);
        checkOutput("reset_DATA_R1", DATA_R1, 32'd0);

        applyStimulus(0, 0, 0, 1, 4'd3, 4'd15, 0, 0);
        checkOutput("rd_after_reset_R1", DATA_R1, 32'd0);
        checkOutput("rd_after_reset_R2", DATA_R2, 32'd0);
        checkOutput("rd_after_reset_valid", {31'b0, R_VALID}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("valid_one_cycle", {31'b0, R_VALID}, 32'd0);

        applyStimulus(1, 4'd5, 32'd24, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 4'd5, 4'd5, 0, 0);
        checkOutput("rd5_R1", DATA_R1, 32'd24);
        checkOutput("rd5_R2", DATA_R2, 32'd24);

        applyStimulus(1, 4'd7, 32'd72, 0, 0, 0, 0, 0);
        applyStimulus(1, 4'd7, 32'hFFFFFFE7, 1, 4'd7, 4'd5, 0, 0);
`ifdef REG_BANK_BYPASS_EN
        checkOutput("same_edge_rw_R1", DATA_R1, 32'hFFFFFFE7);
`else
        checkOutput("same_edge_rw_R1", DATA_R1, 32'd72);
`endif
        checkOutput("same_edge_rw_R2", DATA_R2, 32'd24);
        applyStimulus(0, 0, 0, 1, 4'd7, 4'd7, 0, 0);
        checkOutput("rd7_after_write", DATA_R1, 32'hFFFFFFE7);

        // Sweep with a write and a second clear request landing mid-sweep.
        for (int i = 0; i < 16; i++) applyStimulus(1, 4'(i), 32'(16 - i), 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        busyCycles = 0;
        guard = 0;
        while (BUSY === 1'b1 && guard < 40) begin
            busyCycles++;
            guard++;
            applyStimulus(busyCycles == 5, 4'd2, 32'd99, 1'b1, 4'd2, 4'd3, busyCycles == 8, 1'b0);
        end
        checkOutput("sweep_busy_len", 32'(busyCycles), 32'd16);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 0, 1, 4'(i), 4'(15 - i), 0, 0);
            checkOutput("sweep_zero_R1", DATA_R1, 32'd0);
            checkOutput("sweep_zero_R2", DATA_R2, 32'd0);
        end

        // Reset aborting a sweep partway through.
        for (int i = 0; i < 16; i++) applyStimulus(1, 4'(i), 32'd9, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        busyCycles = 0;
        guard = 0;
        while (BUSY === 1'b1 && guard < 40) begin
            busyCycles++;
            guard++;
            applyStimulus(0, 0, 0, 0, 0, 0, 0, busyCycles == 8);
        end
        checkOutput("abort_busy_cycles", 32'(busyCycles), 32'd8);
        checkOutput("abort_BUSY", {31'b0, BUSY}, 32'd0);
        for (int i = 0; i < 16; i += 2) begin
            applyStimulus(0, 0, 0, 1, 4'(i), 4'(i + 1), 0, 0);
            checkOutput("abort_zero_R1", DATA_R1, 32'd0);
            checkOutput("abort_zero_R2", DATA_R2, 32'd0);
        end
        applyStimulus(1, 4'd1, 32'd4, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 4'd1, 4'd0, 0, 0);
        checkOutput("post_abort_rd1", DATA_R1, 32'd4);

        // Clear, write and read all on the same idle edge.
        applyStimulus(1, 4'd4, 32'd55, 0, 0, 0, 0, 0);
        applyStimulus(1, 4'd4, 32'd66, 1, 4'd4, 4'd1, 1, 0);
`ifdef REG_BANK_BYPASS_EN
        checkOutput("clr_rw_R1", DATA_R1, 32'd66);
`else
        checkOutput("clr_rw_R1", DATA_R1, 32'd55);
`endif
        checkOutput("clr_rw_valid", {31'b0, R_VALID}, 32'd1);
        checkOutput("clr_rw_busy", {31'b0, BUSY}, 32'd1);

        for (int n = 0; n < 800; n++) begin
            applyStimulus($urandom_range(0, 99) < 50, 4'($urandom_range(0, 15)), $urandom,
                          $urandom_range(0, 99) < 50, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          $urandom_range(0, 99) < 3, $urandom_range(0, 199) < 2);
        end

        @(negedge CLK);
        #1;
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
